data_mem_arbiter: RTL and testbench

Shares the single `data_mem` port between `NREQ` requesters: port 0 is the CPU load/store stage and port 1 is the debug/program-loader port. Each requester issues one transaction at a time over a req/ack/done handshake. The arbiter grants access round-robin and sequences the `read`/`write` strobes into `data_mem`. It also returns `read_val` to the granted requester and rejects misaligned accesses before they reach memory.

---
 rtl/data_mem_arbiter_pkg.sv | 32 +++
 rtl/rr_arbiter.sv | 34 +++
 rtl/data_mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_mem_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types, funct3 codes and the alignment rule for the data_mem arbiter.
// Imported by the arbiter top level.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_SW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Only the size bits matter; size code 11 has no legal RV32I access.
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] addr_lo);
    logic mis;
    casez (f3)
      3'b?00:  mis = 1'b0;
      3'b?01:  mis = addr_lo[0];
      3'b?10:  mis = (addr_lo != 2'b00);
      default: mis = 1'b1;
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant search: the first eligible requester at or
// after ptr wins. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] mask,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt_oh,
  output logic [IW-1:0]   gnt_idx,
  output logic            gnt_valid
);

  logic [NREQ-1:0] eligible;

  assign eligible = req & ~mask;

  // NOTE: every output gets a default before the search so no path through
  // the loop leaves a signal unassigned, which would infer a latch.
  always_comb begin
    gnt_oh    = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!gnt_valid && eligible[(int'(ptr) + i) % NREQ]) begin
        gnt_valid                         = 1'b1;
        gnt_idx                           = IW'((int'(ptr) + i) % NREQ);
        gnt_oh[(int'(ptr) + i) % NREQ]    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one data_mem port between NREQ requesters with a
// req/ack/done handshake; misaligned or illegal-width accesses never reach memory.
module data_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int AW   = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           we,
  input  logic [NREQ-1:0][2:0]      funct3,
  input  logic [NREQ-1:0][AW-1:0]   addr,
  input  logic [NREQ-1:0][31:0]     wdata,
  output logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           done,
  output logic                      err,
  output logic [31:0]               rdata,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [2:0]                mem_funct3,
  output logic [AW-1:0]             mem_addr,
  output logic [31:0]               mem_wval,
  input  logic [31:0]               mem_rval
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e       state_q, state_d;
  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    gidx_q, gidx_d;
  logic             we_q, we_d;
  logic [2:0]       f3_q, f3_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [NREQ-1:0]  ack_q, ack_d;

  logic [NREQ-1:0]  cur_oh;
  logic [NREQ-1:0]  arb_mask;
  logic [NREQ-1:0]  gnt_oh;
  logic [IW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic             take;
  logic             bad_access;

  function automatic logic [IW-1:0] next_ptr(input logic [IW-1:0] g);
    if (int'(g) >= NREQ - 1) return '0;
    return g + 1'b1;
  endfunction

  assign cur_oh     = NREQ'(1) << gidx_q;
  assign bad_access = misaligned(f3_q, addr_q[1:0]);

  // The port just served still holds req during RESP, so it sits out this round.
  assign arb_mask = (state_q == ST_RESP) ? cur_oh : '0;

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_rr_arbiter (
    .req       (req),
    .mask      (arb_mask),
    .ptr       (ptr_q),
    .gnt_oh    (gnt_oh),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    we_d    = we_q;
    f3_d    = f3_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = '0;
    take    = 1'b0;

    case (state_q)
      ST_IDLE:  take = gnt_valid;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP: begin
        take = gnt_valid;
        if (!gnt_valid) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (take) begin
      state_d = ST_ISSUE;
      gidx_d  = gnt_idx;
      we_d    = we[gnt_idx];
      f3_d    = funct3[gnt_idx];
      addr_d  = addr[gnt_idx];
      wdata_d = wdata[gnt_idx];
      ack_d   = gnt_oh;
      ptr_d   = next_ptr(gnt_idx);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values; reset is synchronous, so it is just the first branch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
    end
  end

  assign ack        = ack_q;
  assign mem_read   = (state_q == ST_ISSUE) && !we_q && !bad_access;
  assign mem_write  = (state_q == ST_ISSUE) &&  we_q && !bad_access;
  assign mem_funct3 = f3_q;
  assign mem_addr   = addr_q;
  assign mem_wval   = wdata_q;

  // Response is combinational from the memory so both flow-through and
  // registered-read data_mem variants return the right value during RESP.
  assign done  = (state_q == ST_RESP) ? cur_oh : '0;
  assign err   = (state_q == ST_RESP) && bad_access;
  assign rdata = ((state_q == ST_RESP) && !we_q && !bad_access) ? mem_rval : 32'd0;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Bench for data_mem_arbiter: acts as data_mem, runs directed and random
// traffic, and checks every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_data_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NREQ = 2;
  localparam int AW   = 8;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NREQ-1:0]         req, we;
  logic [NREQ-1:0][2:0]    funct3;
  logic [NREQ-1:0][AW-1:0] addr;
  logic [NREQ-1:0][31:0]   wdata;
  logic [NREQ-1:0]         ack, done;
  logic                    err;
  logic [31:0]             rdata;
  logic                    mem_read, mem_write;
  logic [2:0]              mem_funct3;
  logic [AW-1:0]           mem_addr;
  logic [31:0]             mem_wval, mem_rval;

  always #5 clk = ~clk;

  data_mem_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .we         (we),
    .funct3     (funct3),
    .addr       (addr),
    .wdata      (wdata),
    .ack        (ack),
    .done       (done),
    .err        (err),
    .rdata      (rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_funct3 (mem_funct3),
    .mem_addr   (mem_addr),
    .mem_wval   (mem_wval),
    .mem_rval   (mem_rval)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int ack_log[$];
  int strobe_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- data_mem stand-in and shared helpers ----------------
  logic [7:0] dmem    [256];
  logic [7:0] ref_mem [256];

  function automatic int nbytes(input logic [2:0] f);
    if (f[1:0] == 2'b00) return 1;
    if (f[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] extend(input logic [2:0] f, input logic [31:0] raw);
    case (f[1:0])
      2'b00:   return f[2] ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'b01:   return f[2] ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  function automatic bit bad_ref(input logic [2:0] f, input logic [7:0] a);
    if (f[1:0] == 2'b11) return 1'b1;
    return (int'(a) % nbytes(f)) != 0;
  endfunction

  always_comb
    mem_rval = extend(mem_funct3, {dmem[8'(mem_addr + 8'd3)], dmem[8'(mem_addr + 8'd2)],
                                   dmem[8'(mem_addr + 8'd1)], dmem[mem_addr]});

  always @(posedge clk) begin
    cyc++;
    if (mem_write)
      for (int i = 0; i < nbytes(mem_funct3); i++)
        dmem[8'(mem_addr + 8'(i))] = mem_wval[8*i +: 8];
  end

  always @(negedge clk) begin
    for (int p = 0; p < NREQ; p++) if (ack[p]) ack_log.push_back(p);
    if (mem_read || mem_write) strobe_cnt++;
  end

  // ---------------- transaction-level reference model ----------------
  // m_busy: 2 = cycle in which the granted access is strobed, 1 = its done
  // cycle, 0 = no access in progress.
  int          m_busy = 0;
  int          m_cur  = 0;
  int          m_ptr  = 0;
  logic        m_we   = 1'b0;
  logic [2:0]  m_f3   = 3'd0;
  logic [7:0]  m_addr = 8'd0;
  logic [31:0] m_wdata = 32'd0;

  task automatic model_step();
    int excl;
    if (m_busy == 2 && m_we && !bad_ref(m_f3, m_addr))
      for (int i = 0; i < nbytes(m_f3); i++) ref_mem[8'(m_addr + 8'(i))] = m_wdata[8*i +: 8];
    if (reset) begin
      m_busy = 0; m_ptr = 0; m_cur = 0;
      m_we = 1'b0; m_f3 = 3'd0; m_addr = 8'd0; m_wdata = 32'd0;
    end else if (m_busy == 2) begin
      m_busy = 1;
    end else begin
      excl   = (m_busy == 1) ? m_cur : -1;
      m_busy = 0;
      for (int k = 0; k < NREQ; k++) begin
        int p;
        p = (m_ptr + k) % NREQ;
        if (m_busy == 0 && req[p] && p != excl) begin
          m_busy = 2; m_cur = p; m_ptr = (p + 1) % NREQ;
          m_we = we[p]; m_f3 = funct3[p]; m_addr = addr[p]; m_wdata = wdata[p];
        end
      end
    end
  endtask

  task automatic compare();
    logic [NREQ-1:0] cur_oh;
    logic            bad;
    cur_oh = NREQ'(1) << m_cur;
    bad    = bad_ref(m_f3, m_addr);
    check("ack",        ack,        (m_busy == 2) ? cur_oh : '0);
    check("done",       done,       (m_busy == 1) ? cur_oh : '0);
    check("mem_read",   mem_read,   (m_busy == 2) && !m_we && !bad);
    check("mem_write",  mem_write,  (m_busy == 2) &&  m_we && !bad);
    check("mem_addr",   mem_addr,   m_addr);
    check("mem_funct3", mem_funct3, m_f3);
    check("mem_wval",   mem_wval,   m_wdata);
    if (m_busy == 1) begin
      check("err", err, bad);
      check("rdata", rdata, (m_we || bad) ? 32'd0 :
            extend(m_f3, {ref_mem[8'(m_addr + 8'd3)], ref_mem[8'(m_addr + 8'd2)],
                          ref_mem[8'(m_addr + 8'd1)], ref_mem[m_addr]}));
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
    end
  end

  // ---------------- requester drivers ----------------
  task automatic do_txn(input int p, input logic w, input logic [2:0] f, input logic [7:0] a,
                        input logic [31:0] d, output logic [31:0] rd, output logic er,
                        output int lat);
    int start, n;
    @(negedge clk); #1;
    req[p] = 1'b1; we[p] = w; funct3[p] = f; addr[p] = a; wdata[p] = d;
    start = cyc;
    n = 0;
    rd = 32'd0; er = 1'b0; lat = -1;
    while (1) begin
      @(negedge clk);
      if (done[p]) begin
        rd = rdata; er = err; lat = cyc - start;
        break;
      end
      n++;
      if (n > 40) begin
        check($sformatf("done_wait_p%0d", p), {31'd0, done[p]}, 32'd1);
        break;
      end
    end
    #1 req[p] = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; req = '0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic rand_port(input int p);
    logic [31:0] rd;
    logic        er;
    int          lat;
    logic        w;
    logic [2:0]  f;
    logic [7:0]  a;
    logic [2:0]  load_codes [6];
    load_codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011};
    for (int t = 0; t < 80; t++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      w = 1'($urandom_range(0, 1));
      f = w ? 3'($urandom_range(0, 3)) : load_codes[$urandom_range(0, 5)];
      a = 8'($urandom);
      if ($urandom_range(0, 1) == 1) a = a & 8'hFC;
      do_txn(p, w, f, a, $urandom, rd, er, lat);
    end
  endtask

  initial begin
    logic [31:0] rd0, rd1;
    logic        er0, er1;
    int          lat0, lat1, s0;
    for (int i = 0; i < 256; i++) begin
      dmem[i]    = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    reset = 1'b1; req = '0; we = '0; funct3 = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ack",  ack,  '0);
    check("reset_done", done, '0);
    check("reset_strb", {mem_read, mem_write}, 2'b00);
    check("reset_addr", mem_addr, '0);
    check("reset_rdat", rdata, 32'd0);
    #1 reset = 1'b0;

    // Store then load on port 0
    s0 = strobe_cnt;
    do_txn(0, 1'b1, F3_SW, 8'd0, 32'd247, rd0, er0, lat0);
    check("sw_latency", lat0, 2);
    check("sw_err", er0, 1'b0);
    check("sw_one_strobe", strobe_cnt - s0, 1);
    do_txn(0, 1'b0, F3_LW, 8'd0, 32'd0, rd0, er0, lat0);
    check("lw_latency", lat0, 2);
    check("lw_rdata", rd0, 32'd247);
    check("lw_err", er0, 1'b0);

    // Simultaneous requests straight after reset
    do_reset();
    fork
      do_txn(0, 1'b1, F3_SW, 8'd8,  32'h1111_2222, rd0, er0, lat0);
      do_txn(1, 1'b1, F3_SW, 8'd12, 32'h3333_4444, rd1, er1, lat1);
    join
    check("simul_done0_cycle", lat0, 2);
    check("simul_done1_cycle", lat1, 4);

    // Fairness under continuous demand
    ack_log.delete();
    fork
      repeat (4) do_txn(0, 1'b0, F3_LW, 8'd8,  32'd0, rd0, er0, lat0);
      repeat (4) do_txn(1, 1'b0, F3_LW, 8'd12, 32'd0, rd1, er1, lat1);
    join
    check("fair_len", ack_log.size(), 8);
    for (int i = 0; i < ack_log.size() && i < 8; i++)
      check($sformatf("fair_grant%0d", i), ack_log[i], i % 2);
    check("fair_rdata1", rd1, 32'h3333_4444);

    // Misalignment and illegal width
    s0 = strobe_cnt;
    do_txn(0, 1'b0, F3_LW, 8'd6, 32'd0, rd0, er0, lat0);
    check("lw6_err", er0, 1'b1);
    check("lw6_rdata", rd0, 32'd0);
    do_txn(1, 1'b0, F3_LH, 8'd5, 32'd0, rd0, er0, lat0);
    check("lh5_err", er0, 1'b1);
    do_txn(0, 1'b0, 3'b011, 8'd4, 32'd0, rd0, er0, lat0);
    check("ill_ld_err", er0, 1'b1);
    do_txn(1, 1'b1, 3'b011, 8'd0, 32'd99, rd0, er0, lat0);
    check("ill_st_err", er0, 1'b1);
    check("no_strobes", strobe_cnt - s0, 0);
    do_txn(0, 1'b1, F3_SB, 8'd5, 32'd453, rd0, er0, lat0);
    check("sb5_err", er0, 1'b0);
    do_txn(0, 1'b0, F3_LBU, 8'd5, 32'd0, rd0, er0, lat0);
    check("lbu5_rdata", rd0, 32'd197);
    do_txn(1, 1'b0, F3_LB, 8'd5, 32'd0, rd0, er0, lat0);
    check("lb5_rdata", rd0, 32'hFFFF_FFC5);
    do_txn(1, 1'b0, F3_LW, 8'd0, 32'd0, rd0, er0, lat0);
    check("ill_st_nowrite", rd0, 32'd247);

    // Reset in the ISSUE cycle: the access is dropped and ptr returns to 0
    @(negedge clk); #1;
    req[0] = 1'b1; we[0] = 1'b0; funct3[0] = F3_LW; addr[0] = 8'd0;
    @(negedge clk);
    check("mid_ack", ack, 2'b01);
    #1 reset = 1'b1; req[0] = 1'b0;
    @(negedge clk);
    check("mid_no_done", done, '0);
    check("mid_strobes", {mem_read, mem_write}, 2'b00);
    #1 reset = 1'b0;
    ack_log.delete();
    fork
      do_txn(0, 1'b0, F3_LW, 8'd8,  32'd0, rd0, er0, lat0);
      do_txn(1, 1'b0, F3_LW, 8'd12, 32'd0, rd1, er1, lat1);
    join
    check("mid_ptr_first", (ack_log.size() > 0) ? ack_log[0] : -1, 0);

    // Random concurrent traffic, checked cycle by cycle by the model
    fork
      rand_port(0);
      rand_port(1);
    join

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
